mix_wt_writer: RTL and testbench

Transpose engine for the mixing-layer weights. After the optimizer updates `W`, this block reads `W` from the weight RAM in DATA_N×DATA_N tiles, transposes each tile in a local buffer and writes the result into the transposed-weight RAM. It is the writer for the `W^T` store that the forward pass reads.

---
 rtl/mix_wt_writer.sv | 153 +++++++++++++++
 tb/tb_mix_wt_writer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mix_wt_writer.sv
// mix_wt_writer
//   Transpose engine for the mixing-layer weights. Reads W from the weight RAM
//   in DATA_N x DATA_N tiles, transposes each tile in a local buffer and writes
//   it to the W^T RAM. Three matrices of HID_DIM x HID_DIM elements are handled;
//   each RAM word packs DATA_N elements of N_LEN_W bits.
//   HID_DIM / DATA_N / N_LEN_W carry the sizing of consts_train.vh.
//
// Ports
//   clk    : single clock
//   rst_n  : asynchronous active-low reset
//   run    : level request, the block works while high
//   valid  : transpose complete, held while run stays high
//   raddr  : W RAM read address (1-cycle synchronous read)
//   rdata  : W RAM read data
//   load   : W^T RAM write enable
//   waddr  : W^T RAM write address
//   wdata  : W^T RAM write data
module mix_wt_writer #(
  parameter int ADDR_WIDTH = 9,
  parameter int HID_DIM    = 24,
  parameter int DATA_N     = 6,
  parameter int N_LEN_W    = 18
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      run,
  output logic                      valid,
  output logic [ADDR_WIDTH-1:0]     raddr,
  input  logic [DATA_N*N_LEN_W-1:0] rdata,
  output logic                      load,
  output logic [ADDR_WIDTH-1:0]     waddr,
  output logic [DATA_N*N_LEN_W-1:0] wdata
);

  localparam int P  = HID_DIM / DATA_N;     // words per row
  localparam int M  = HID_DIM * P;          // words per matrix
  localparam int JW = (DATA_N > 1) ? $clog2(DATA_N) : 1;
  localparam int PW = (P > 1) ? $clog2(P) : 1;

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

  state_t                    state_q, state_d;
  logic [JW-1:0]             j_q;
  logic [1:0]                m_q;
  logic [PW-1:0]             br_q, bc_q;
  logic [DATA_N*N_LEN_W-1:0] buf_q [DATA_N];

  logic j_last, bc_last, br_last, tile_last;

  assign j_last    = (j_q == JW'(DATA_N - 1));
  assign bc_last   = (bc_q == PW'(P - 1));
  assign br_last   = (br_q == PW'(P - 1));
  assign tile_last = (m_q == 2'd2) && br_last && bc_last;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    if (!run) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = READ;
        READ:    if (j_last) state_d = WAIT;
        WAIT:    state_d = WRITE;
        WRITE:   if (j_last) state_d = tile_last ? DONE : READ;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Tile counters (m outer, br, bc inner) and the per-tile row index j/k
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      j_q  <= '0;
      m_q  <= '0;
      br_q <= '0;
      bc_q <= '0;
    end else if (!run) begin
      j_q  <= '0;
      m_q  <= '0;
      br_q <= '0;
      bc_q <= '0;
    end else begin
      case (state_q)
        READ:  j_q <= j_last ? '0 : j_q + 1'b1;
        WAIT:  j_q <= '0;
        WRITE: begin
          if (j_last) begin
            j_q <= '0;
            if (!tile_last) begin
              if (bc_last) begin
                bc_q <= '0;
                if (br_last) begin
                  br_q <= '0;
                  m_q  <= m_q + 1'b1;
                end else begin
                  br_q <= br_q + 1'b1;
                end
              end else begin
                bc_q <= bc_q + 1'b1;
              end
            end
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        default: j_q <= '0;
      endcase
    end
  end

  // Read data for READ j arrives one cycle later: captured during READ j+1,
  // and the last row during WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DATA_N; i++) buf_q[i] <= '0;
    end else if (state_q == READ && j_q != '0) begin
      buf_q[j_q - 1'b1] <= rdata;
    end else if (state_q == WAIT) begin
      buf_q[DATA_N-1] <= rdata;
    end
  end

  // Outputs decoded from registered state
  always_comb begin
    raddr = '0;
    waddr = '0;
    wdata = '0;
    load  = 1'b0;
    valid = (state_q == DONE);
    case (state_q)
      READ: begin
        raddr = ADDR_WIDTH'(int'(m_q) * M + (int'(bc_q) * DATA_N + int'(j_q)) * P + int'(br_q));
      end
      WRITE: begin
        load  = 1'b1;
        waddr = ADDR_WIDTH'(int'(m_q) * M + (int'(br_q) * DATA_N + int'(j_q)) * P + int'(bc_q));
        // element e of the output word is element k of buffered row e
        for (int unsigned e = 0; e < DATA_N; e++)
          wdata[e*N_LEN_W +: N_LEN_W] = buf_q[e][int'(j_q)*N_LEN_W +: N_LEN_W];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mix_wt_writer.sv
module tb_mix_wt_writer;

  localparam int AW  = 9;
  localparam int HD  = 24;
  localparam int DN  = 6;
  localparam int NL  = 18;
  localparam int P   = HD / DN;
  localparam int M   = HD * P;
  localparam int NW  = 3 * M;
  localparam int LAT = 624;

  logic              clk, rst_n, run, valid, load;
  logic [AW-1:0]     raddr, waddr;
  logic [DN*NL-1:0]  rdata, wdata;

  logic [DN*NL-1:0]  wram [512];
  logic [DN*NL-1:0]  wt   [512];
  int                wcnt [512];

  int total, bad;
  int fv, last_load_n, load_cnt, dup_cnt, align_err;
  int ra0, ra1, wa0, wa1;

  mix_wt_writer #(.ADDR_WIDTH(AW), .HID_DIM(HD), .DATA_N(DN), .N_LEN_W(NL)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .valid(valid), .raddr(raddr),
    .rdata(rdata), .load(load), .waddr(waddr), .wdata(wdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) rdata <= wram[raddr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise run and follow one transpose until valid (bounded), modelling the
  // W^T RAM and recording the statistics the tests compare.
  task automatic run_collect();
    int n, t, k, mm, br, bc;
    logic [AW-1:0]    ea;
    logic [DN*NL-1:0] ed, rw;
    for (int i = 0; i < 512; i++) begin
      wt[i] = '0;
      wcnt[i] = 0;
    end
    fv = -1; last_load_n = -1; load_cnt = 0; dup_cnt = 0; align_err = 0;
    ra0 = -1; ra1 = -1; wa0 = -1; wa1 = -1;
    run = 1'b1;
    tick();
    n = 0;
    while (n <= 700) begin
      if (n == 0) ra0 = int'(raddr);
      if (n == 1) ra1 = int'(raddr);
      if (valid) begin
        fv = n;
        break;
      end
      if (load) begin
        if (load_cnt == 0) wa0 = int'(waddr);
        if (load_cnt == 1) wa1 = int'(waddr);
        t  = load_cnt / DN;
        k  = load_cnt % DN;
        mm = t / (P * P);
        br = (t / P) % P;
        bc = t % P;
        ea = AW'(mm * M + (br * DN + k) * P + bc);
        for (int j = 0; j < DN; j++) begin
          rw = wram[mm * M + (bc * DN + j) * P + br];
          ed[j*NL +: NL] = rw[k*NL +: NL];
        end
        if (waddr !== ea || wdata !== ed) align_err++;
        if (wcnt[waddr] != 0) dup_cnt++;
        wcnt[waddr]++;
        wt[waddr] = wdata;
        load_cnt++;
        last_load_n = n;
      end
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    run = 1'b0;
    rst_n = 1'b0;
    #12;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", valid); end
    total++; if (load !== 1'b0) begin bad++; $display("FAIL reset_load: got %0b want 0", load); end
    total++; if (raddr !== '0) begin bad++; $display("FAIL reset_raddr: got %0d want 0", raddr); end
    total++; if (waddr !== '0) begin bad++; $display("FAIL reset_waddr: got %0d want 0", waddr); end
    total++; if (wdata !== '0) begin bad++; $display("FAIL reset_wdata: got %0h want 0", wdata); end
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_transpose();
    int errs, nv, nl;
    logic [DN*NL-1:0] w;
    logic [NL-1:0] exp_e;
    for (int m = 0; m < 3; m++)
      for (int r = 0; r < HD; r++)
        for (int cw = 0; cw < P; cw++) begin
          for (int e = 0; e < DN; e++)
            w[e*NL +: NL] = NL'((m << 10) | (r << 5) | (cw * DN + e));
          wram[m * M + r * P + cw] = w;
        end
    run_collect();
    total++; if (fv !== LAT) begin bad++; $display("FAIL latency: valid at cycle %0d want %0d", fv, LAT); end
    total++; if (last_load_n !== LAT - 1) begin bad++; $display("FAIL last_load: at cycle %0d want %0d", last_load_n, LAT - 1); end
    total++; if (load_cnt !== NW) begin bad++; $display("FAIL load_count: got %0d want %0d", load_cnt, NW); end
    total++; if (dup_cnt !== 0) begin bad++; $display("FAIL dup_writes: got %0d want 0", dup_cnt); end
    total++; if (ra0 !== 0) begin bad++; $display("FAIL first_raddr: got %0d want 0", ra0); end
    total++; if (ra1 !== 4) begin bad++; $display("FAIL second_raddr: got %0d want 4", ra1); end
    total++; if (wa0 !== 0) begin bad++; $display("FAIL first_waddr: got %0d want 0", wa0); end
    total++; if (wa1 !== 4) begin bad++; $display("FAIL second_waddr: got %0d want 4", wa1); end
    total++; if (align_err !== 0) begin bad++; $display("FAIL full_write_order: got %0d bad writes want 0", align_err); end
    errs = 0;
    for (int m = 0; m < 3; m++)
      for (int r = 0; r < HD; r++)
        for (int cw = 0; cw < P; cw++) begin
          w = wt[m * M + r * P + cw];
          for (int e = 0; e < DN; e++) begin
            exp_e = NL'((m << 10) | ((cw * DN + e) << 5) | r);
            if (w[e*NL +: NL] !== exp_e) errs++;
          end
        end
    total++; if (errs !== 0) begin bad++; $display("FAIL wt_contents: got %0d bad elements want 0", errs); end
    // hold in DONE
    nv = 0; nl = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (valid !== 1'b1) nv++;
      if (load !== 1'b0) nl++;
    end
    total++; if (nv !== 0) begin bad++; $display("FAIL done_hold_valid: got %0d low cycles want 0", nv); end
    total++; if (nl !== 0) begin bad++; $display("FAIL done_hold_load: got %0d load cycles want 0", nl); end
    run = 1'b0;
    tick();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL done_drop_valid: got %0b want 0", valid); end
  endtask

  task automatic test_abort();
    run = 1'b1;
    tick();
    for (int i = 0; i < 74; i++) tick();  // tile 5 WRITE, k=2
    total++; if (load !== 1'b1) begin bad++; $display("FAIL abort_pre_load: got %0b want 1", load); end
    run = 1'b0;
    tick();
    total++; if (load !== 1'b0) begin bad++; $display("FAIL abort_load: got %0b want 0", load); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL abort_valid: got %0b want 0", valid); end
    total++; if (waddr !== '0) begin bad++; $display("FAIL abort_waddr: got %0d want 0", waddr); end
    run_collect();
    total++; if (ra0 !== 0) begin bad++; $display("FAIL restart_raddr: got %0d want 0", ra0); end
    total++; if (fv !== LAT) begin bad++; $display("FAIL restart_latency: valid at cycle %0d want %0d", fv, LAT); end
    total++; if (load_cnt !== NW) begin bad++; $display("FAIL restart_load_count: got %0d want %0d", load_cnt, NW); end
    run = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    run = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) tick();
    total++; if (raddr !== AW'(12)) begin bad++; $display("FAIL pre_reset_raddr: got %0d want 12", raddr); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (load !== 1'b0) begin bad++; $display("FAIL areset_load: got %0b want 0", load); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL areset_valid: got %0b want 0", valid); end
    total++; if (raddr !== '0) begin bad++; $display("FAIL areset_raddr: got %0d want 0", raddr); end
    total++; if (waddr !== '0) begin bad++; $display("FAIL areset_waddr: got %0d want 0", waddr); end
    tick();
    tick();
    total++; if (load !== 1'b0 || raddr !== '0) begin bad++; $display("FAIL areset_hold: got load=%0b raddr=%0d want 0/0", load, raddr); end
    run = 1'b0;
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read_alignment();
    int errs;
    logic [DN*NL-1:0] w, src, dst;
    for (int a = 0; a < NW; a++) begin
      for (int e = 0; e < DN; e++) w[e*NL +: NL] = NL'((a << 3) | e);
      wram[a] = w;
    end
    run_collect();
    total++; if (align_err !== 0) begin bad++; $display("FAIL tag_alignment: got %0d bad writes want 0", align_err); end
    total++; if (load_cnt !== NW) begin bad++; $display("FAIL tag_load_count: got %0d want %0d", load_cnt, NW); end
    errs = 0;
    for (int m = 0; m < 3; m++)
      for (int r = 0; r < HD; r++)
        for (int c = 0; c < HD; c++) begin
          src = wram[m * M + c * P + r / DN];
          dst = wt[m * M + r * P + c / DN];
          if (dst[(c % DN)*NL +: NL] !== src[(r % DN)*NL +: NL]) errs++;
        end
    total++; if (errs !== 0) begin bad++; $display("FAIL tag_contents: got %0d bad elements want 0", errs); end
    run = 1'b0;
    tick();
  endtask

  initial begin
    total = 0;
    bad = 0;
    run = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 512; i++) wram[i] = '0;
    test_reset();
    test_full_transpose();
    test_abort();
    test_async_reset();
    test_read_alignment();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
